// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared command encodings for the queue store and its control block
package queue_pkg;

   // Command driven by the control block on the flag input
   typedef enum logic [1:0] {
      FLAG_HOLD = 2'b00,
      FLAG_WR   = 2'b01,
      FLAG_RD   = 2'b10,
      FLAG_RW   = 2'b11
   } flag_e;

endpackage

// File: rtl/queue_ram.sv
// rtl/queue_ram.sv - DEPTH x DATA_W storage array, synchronous write, registered read with enable
module queue_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] rdata_q;

   // Array contents are deliberately left out of reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read data holds unless a read is enabled; a same-edge write to raddr returns the old word
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // Read data register, cleared by reset so dout starts at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/queue_store.sv
// rtl/queue_store.sv - circular-buffer queue with sticky errors; QUEUE_STORE_ALMOST_EN adds almost_full/almost_empty
module queue_store
   import queue_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 flag,
   input  logic [DATA_W-1:0]          din,
   output logic [DATA_W-1:0]          dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err_ovf,
   output logic                       err_udf
`ifdef QUEUE_STORE_ALMOST_EN
   ,
   output logic                       almost_full,
   output logic                       almost_empty
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wp_d, wp_q;
   logic [PTR_W-1:0] rp_d, rp_q;
   logic [CNT_W-1:0] count_d, count_q;
   logic             err_ovf_d, err_ovf_q;
   logic             err_udf_d, err_udf_q;
   logic             wr_req, rd_req;
   logic             do_wr, do_rd;

   // Status comes only from registered count so it never depends on flag or din
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;

`ifdef QUEUE_STORE_ALMOST_EN
   assign almost_full  = (count_q >= CNT_W'(DEPTH - 1));
   assign almost_empty = (count_q <= CNT_W'(1));
`endif

   // Decode the command, qualify it against occupancy, and compute next pointer/count/error state
   always_comb begin
      wr_req = 1'b0;
      rd_req = 1'b0;
      case (flag_e'(flag))
         FLAG_WR: wr_req = 1'b1;
         FLAG_RD: rd_req = 1'b1;
         FLAG_RW: begin
            wr_req = 1'b1;
            rd_req = 1'b1;
         end
         default: ;
      endcase

      // A write into a full queue is only legal when a read frees the slot on the same edge
      do_rd = rd_req && !empty;
      do_wr = wr_req && (!full || do_rd);

      wp_d = do_wr ? wp_q + PTR_W'(1) : wp_q;
      rp_d = do_rd ? rp_q + PTR_W'(1) : rp_q;

      count_d = count_q;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Read+write on an empty queue degrades to a plain write and is not an underflow
      err_ovf_d = err_ovf_q | (wr_req && !rd_req && full);
      err_udf_d = err_udf_q | (rd_req && !wr_req && empty);
   end

   // Pointer, count and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q      <= '0;
         rp_q      <= '0;
         count_q   <= '0;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         count_q   <= count_d;
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   queue_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (do_wr),
      .waddr (wp_q),
      .wdata (din),
      .re    (do_rd),
      .raddr (rp_q),
      .rdata (dout)
   );

endmodule

// File: tb/tb_queue_store.sv
// tb/tb_queue_store.sv - self-checking bench for queue_store against a queue-based reference model
module tb_queue_store;

   logic       clk;
   logic       rst;
   logic [1:0] flag;
   logic [7:0] din;
   logic [7:0] dout;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       err_ovf;
   logic       err_udf;
`ifdef QUEUE_STORE_ALMOST_EN
   logic       almost_full;
   logic       almost_empty;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Reference model: a plain FIFO of bytes plus last read word and sticky flags
   logic [7:0] m_q[$];
   logic [7:0] m_dout;
   logic       m_ovf;
   logic       m_udf;

   queue_store #(.DATA_W(8), .DEPTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .flag    (flag),
      .din     (din),
      .dout    (dout),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .err_ovf (err_ovf),
      .err_udf (err_udf)
`ifdef QUEUE_STORE_ALMOST_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = m_q.size();
      chk({tag, "/count"}, 32'(count), 32'(n));
      chk({tag, "/full"}, 32'(full), 32'(n == 8));
      chk({tag, "/empty"}, 32'(empty), 32'(n == 0));
      chk({tag, "/dout"}, 32'(dout), 32'(m_dout));
      chk({tag, "/err_ovf"}, 32'(err_ovf), 32'(m_ovf));
      chk({tag, "/err_udf"}, 32'(err_udf), 32'(m_udf));
`ifdef QUEUE_STORE_ALMOST_EN
      chk({tag, "/almost_full"}, 32'(almost_full), 32'(n >= 7));
      chk({tag, "/almost_empty"}, 32'(almost_empty), 32'(n <= 1));
`endif
   endtask

   task automatic model_reset();
      m_q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   // Apply one command for one clock edge and advance the model by the queue rules
   task automatic step(input logic [1:0] f, input logic [7:0] d);
      bit rd, wr, was_full, was_empty;
      @(negedge clk);
      flag = f;
      din  = d;
      @(posedge clk);
      was_full  = (m_q.size() == 8);
      was_empty = (m_q.size() == 0);
      rd = f[1] && !was_empty;
      wr = f[0] && (!was_full || rd);
      if (f == 2'b01 && was_full)  m_ovf = 1'b1;
      if (f == 2'b10 && was_empty) m_udf = 1'b1;
      if (rd) m_dout = m_q.pop_front();
      if (wr) m_q.push_back(d);
      #1;
   endtask

   // Asynchronous reset asserted between edges and checked before any clock edge
   task automatic async_reset(input string tag);
      @(negedge clk);
      flag = 2'b00;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] v;
      rst  = 1'b1;
      flag = 2'b00;
      din  = 8'h00;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Fill with 0x11..0x88
      for (int i = 1; i <= 8; i++) begin
         v = 8'(i * 8'h11);
         step(2'b01, v);
      end
      check_all("fill8");
      chk("fill8/full_const", 32'(full), 32'd1);

      // Overflow attempt
      step(2'b01, 8'h99);
      check_all("ovf");
      chk("ovf/flag_const", 32'(err_ovf), 32'd1);

      // Drain, each word visible right after its read edge
      for (int i = 1; i <= 8; i++) begin
         step(2'b10, 8'h00);
         chk("drain/dout_const", 32'(dout), 32'(i * 8'h11));
         check_all("drain");
      end

      // Underflow attempt holds dout
      step(2'b10, 8'h00);
      check_all("udf");
      chk("udf/dout_const", 32'(dout), 32'h88);

      // Read+write while full
      for (int i = 1; i <= 8; i++) begin
         v = 8'(i * 8'h11);
         step(2'b01, v);
      end
      step(2'b11, 8'hAA);
      check_all("rw_full");
      chk("rw_full/dout_const", 32'(dout), 32'h11);
      for (int i = 0; i < 8; i++) begin
         step(2'b10, 8'h00);
         check_all("rw_drain");
      end
      chk("rw_drain/last", 32'(dout), 32'hAA);

      // Read+write while empty is a write only
      step(2'b11, 8'h3C);
      check_all("rw_empty");
      step(2'b10, 8'h00);
      check_all("rw_empty_rd");

      // Wrap-around from a clean state
      async_reset("rst_pre_wrap");
      for (int i = 0; i < 20; i++) begin
         v = 8'($urandom);
         step(2'b01, v);
         check_all("wrap_wr");
         step(2'b10, 8'h00);
         chk("wrap/dout_val", 32'(dout), 32'(v));
         check_all("wrap_rd");
      end

      // Random commands against the model
      for (int i = 0; i < 400; i++) begin
         step(2'($urandom_range(0, 3)), 8'($urandom));
         check_all("rand");
      end

      // Reset mid-drain at count 5
      async_reset("rst_pre_mid");
      for (int i = 0; i < 8; i++) step(2'b01, 8'($urandom));
      for (int i = 0; i < 3; i++) step(2'b10, 8'h00);
      chk("mid/count5", 32'(count), 32'd5);
      async_reset("rst_mid");
      step(2'b01, 8'h5A);
      check_all("post_rst_wr");
      step(2'b10, 8'h00);
      check_all("post_rst_rd");
      chk("post_rst/dout_const", 32'(dout), 32'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
